// File: rtl/si_co_bi_mem_wm_model.sv
// Single-port behavioural memory with per-lane write mask and wait states.
// Clears its array after every reset and exerts hold while busy.
//
// Ports:
//   clk_i        clock, all logic on posedge
//   rst_ni       synchronous active-low reset
//   enable_i     request present
//   isWrite_i    1 = write, 0 = read
//   writeMask_i  per-lane write enable (ignored on reads)
//   wrData_i     write data
//   addr_i       word address
//   rdData_o     registered read data (old contents, read-before-write)
//   hold_o       1 = request not accepted this cycle
module si_co_bi_mem_wm_model #(
    parameter int WIDTH       = 16,
    parameter int HEIGHT      = 16,
    parameter int MASK        = 4,
    parameter int WAIT_STATES = 0
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      enable_i,
    input  logic                      isWrite_i,
    input  logic [MASK-1:0]           writeMask_i,
    input  logic [WIDTH-1:0]          wrData_i,
    input  logic [$clog2(HEIGHT)-1:0] addr_i,
    output logic [WIDTH-1:0]          rdData_o,
    output logic                      hold_o
);

    localparam int AW = $clog2(HEIGHT);
    localparam int LW = WIDTH / MASK;

    if (WIDTH % MASK != 0) begin : g_bad_mask
        $error("WIDTH must be divisible by MASK");
    end

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        WAIT  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     clrAddr_q, clrAddr_d;
    logic [7:0]        waitCnt_q, waitCnt_d;
    logic [WIDTH-1:0]  rdData_q;
    logic [WIDTH-1:0]  mem_q [HEIGHT];
    logic              accept;
    logic              clrEn;
    logic              addrOk;

    // Only meaningful for non-power-of-2 HEIGHT.
    assign addrOk = int'(addr_i) < HEIGHT;

    always_comb begin
        state_d   = state_q;
        clrAddr_d = clrAddr_q;
        waitCnt_d = waitCnt_q;
        hold_o    = 1'b1;
        accept    = 1'b0;
        clrEn     = 1'b0;
        case (state_q)
            CLEAR: begin
                clrEn     = 1'b1;
                clrAddr_d = clrAddr_q + 1'b1;
                if (clrAddr_q == AW'(HEIGHT - 1)) begin
                    state_d   = IDLE;
                    clrAddr_d = '0;
                end
            end
            IDLE: begin
                if (!enable_i) begin
                    hold_o = 1'b0;
                end else if (WAIT_STATES == 0) begin
                    hold_o = 1'b0;
                    accept = 1'b1;
                end else begin
                    waitCnt_d = 8'(WAIT_STATES - 1);
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (!enable_i) begin
                    // Requester dropped mid-wait: abandon it.
                    hold_o  = 1'b0;
                    state_d = IDLE;
                end else if (waitCnt_q != 8'd0) begin
                    waitCnt_d = waitCnt_q - 8'd1;
                end else begin
                    hold_o  = 1'b0;
                    accept  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = CLEAR;
        endcase
        // Reset aborts everything in flight, including clearing.
        if (!rst_ni) begin
            hold_o = 1'b1;
            accept = 1'b0;
            clrEn  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= CLEAR;
            clrAddr_q <= '0;
            waitCnt_q <= '0;
            rdData_q  <= '0;
        end else begin
            state_q   <= state_d;
            clrAddr_q <= clrAddr_d;
            waitCnt_q <= waitCnt_d;
            if (accept) begin
                rdData_q <= addrOk ? mem_q[addr_i] : '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (clrEn) begin
            mem_q[clrAddr_q] <= '0;
        end else if (accept && isWrite_i && addrOk) begin
            for (int m = 0; m < MASK; m++) begin
                if (writeMask_i[m]) begin
                    mem_q[addr_i][m*LW +: LW] <= wrData_i[m*LW +: LW];
                end
            end
        end
    end

    assign rdData_o = rdData_q;

endmodule

// File: tb/tb_si_co_bi_mem_wm_model.sv
// Self-checking bench: one instance with no wait states, one with three.
// Table vectors, hand-built timing sequences and random traffic vs a model.
module tb_si_co_bi_mem_wm_model;

    logic        clk = 1'b0;
    logic        rstn [2];
    logic        en   [2];
    logic        we   [2];
    logic [3:0]  msk  [2];
    logic [15:0] wd   [2];
    logic [3:0]  ad   [2];
    logic [15:0] rd   [2];
    logic        hold [2];

    int n_checks = 0;
    int n_fail   = 0;
    int ws [2];

    logic [15:0] model [2][16];

    typedef struct {
        logic        w;
        logic [3:0]  m;
        logic [15:0] d;
        logic [3:0]  a;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t vecs [12];

    always #5 clk = ~clk;

    si_co_bi_mem_wm_model #(.WAIT_STATES(0)) dut0 (
        .clk_i(clk), .rst_ni(rstn[0]), .enable_i(en[0]),
        .isWrite_i(we[0]), .writeMask_i(msk[0]), .wrData_i(wd[0]),
        .addr_i(ad[0]), .rdData_o(rd[0]), .hold_o(hold[0])
    );

    si_co_bi_mem_wm_model #(.WAIT_STATES(3)) dut3 (
        .clk_i(clk), .rst_ni(rstn[1]), .enable_i(en[1]),
        .isWrite_i(we[1]), .writeMask_i(msk[1]), .wrData_i(wd[1]),
        .addr_i(ad[1]), .rdData_o(rd[1]), .hold_o(hold[1])
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reset, then measure how long the clear sequence holds off requests.
    task automatic do_reset(input int d);
        int hc;
        logic done;
        rstn[d] = 1'b0;
        en[d]   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("hold_in_reset", 32'(hold[d]), 32'd1);
        @(posedge clk);
        #1;
        check("rd_after_reset", 32'(rd[d]), 32'd0);
        rstn[d] = 1'b1;
        hc = 0;
        done = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (hold[d]) hc++;
            else done = 1'b1;
            @(posedge clk);
            #1;
        end
        check("clear_done", 32'(done), 32'd1);
        check("clear_len", 32'(hc), 32'd16);
        for (int i = 0; i < 16; i++) model[d][i] = '0;
    endtask

    // One request; checks hold count, read-before-write data, updates model.
    task automatic access(input int d, input logic w, input logic [3:0] m,
                          input logic [15:0] dat, input logic [3:0] a,
                          output logic [15:0] act);
        int hc;
        logic ok;
        logic [15:0] old;
        en[d]  = 1'b1;
        we[d]  = w;
        msk[d] = m;
        wd[d]  = dat;
        ad[d]  = a;
        hc = 0;
        ok = 1'b0;
        for (int c = 0; c < 300 && !ok; c++) begin
            @(negedge clk);
            if (hold[d]) hc++;
            else ok = 1'b1;
            @(posedge clk);
            #1;
        end
        en[d] = 1'b0;
        check("accepted", 32'(ok), 32'd1);
        check("hold_cycles", 32'(hc), 32'(ws[d]));
        old = model[d][a];
        if (w) begin
            for (int l = 0; l < 4; l++)
                if (m[l]) model[d][a][l*4 +: 4] = dat[l*4 +: 4];
        end
        act = rd[d];
        check("rd_model", 32'(act), 32'(old));
    endtask

    initial begin
        logic [15:0] r;
        logic [7:0]  hp;
        logic [15:0] r4, r8, r3;
        ws[0] = 0;
        ws[1] = 3;
        for (int d = 0; d < 2; d++) begin
            rstn[d] = 1'b0; en[d] = 1'b0; we[d] = 1'b0;
            msk[d] = '0; wd[d] = '0; ad[d] = '0;
        end

        vecs[0]  = '{1'b0, 4'b0000, 16'h0000, 4'd7, 16'h0000};
        vecs[1]  = '{1'b1, 4'b1111, 16'hBEEF, 4'd3, 16'h0000};
        vecs[2]  = '{1'b0, 4'b0000, 16'h0000, 4'd3, 16'hBEEF};
        vecs[3]  = '{1'b1, 4'b0101, 16'hFFFF, 4'd5, 16'h0000};
        vecs[4]  = '{1'b0, 4'b0000, 16'h0000, 4'd5, 16'h0F0F};
        vecs[5]  = '{1'b1, 4'b1111, 16'hBEEF, 4'd2, 16'h0000};
        vecs[6]  = '{1'b1, 4'b1111, 16'h1234, 4'd2, 16'hBEEF};
        vecs[7]  = '{1'b0, 4'b0000, 16'h0000, 4'd2, 16'h1234};
        vecs[8]  = '{1'b1, 4'b1000, 16'h0000, 4'd3, 16'hBEEF};
        vecs[9]  = '{1'b0, 4'b0000, 16'h0000, 4'd3, 16'h0EEF};
        vecs[10] = '{1'b1, 4'b0000, 16'hABCD, 4'd5, 16'h0F0F};
        vecs[11] = '{1'b0, 4'b0000, 16'h0000, 4'd5, 16'h0F0F};

        @(posedge clk);
        #1;
        do_reset(0);
        do_reset(1);

        // Table vectors on both instances.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 12; i++) begin
                access(d, vecs[i].w, vecs[i].m, vecs[i].d, vecs[i].a, r);
                check($sformatf("vec%0d_dut%0d", i, d), 32'(r),
                      32'(vecs[i].exp_rd));
            end
        end

        // Back-to-back reads with 3 wait states.
        access(1, 1'b1, 4'hF, 16'h1111, 4'd1, r);
        access(1, 1'b1, 4'hF, 16'h2222, 4'd9, r);
        access(1, 1'b0, 4'h0, 16'h0000, 4'd0, r);
        en[1] = 1'b1; we[1] = 1'b0; ad[1] = 4'd1;
        hp = '0;
        r3 = '0; r4 = '0; r8 = '0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            hp[7-c] = hold[1];
            @(posedge clk);
            #1;
            if (c == 2) r3 = rd[1];
            if (c == 3) begin r4 = rd[1]; ad[1] = 4'd9; end
            if (c == 7) r8 = rd[1];
        end
        en[1] = 1'b0;
        check("b2b_hold", 32'(hp), 32'h000000EE);
        check("b2b_rd_before", 32'(r3), 32'h0000);
        check("b2b_rd1", 32'(r4), 32'h1111);
        check("b2b_rd2", 32'(r8), 32'h2222);

        // Reset during the 2nd hold cycle of a pending write.
        en[1] = 1'b1; we[1] = 1'b1; msk[1] = 4'hF;
        wd[1] = 16'h1234; ad[1] = 4'd2;
        @(negedge clk);
        check("abort_hold1", 32'(hold[1]), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("abort_hold2", 32'(hold[1]), 32'd1);
        rstn[1] = 1'b0;
        en[1] = 1'b0;
        @(posedge clk);
        #1;
        do_reset(1);
        access(1, 1'b0, 4'h0, 16'h0000, 4'd2, r);
        check("abort_rd", 32'(r), 32'h0000);

        // Reset mid-clear restarts the full clear.
        access(0, 1'b1, 4'hF, 16'h5A5A, 4'd15, r);
        rstn[0] = 1'b0;
        @(posedge clk);
        #1;
        rstn[0] = 1'b1;
        for (int c = 0; c < 6; c++) @(posedge clk);
        #1;
        do_reset(0);
        access(0, 1'b0, 4'h0, 16'h0000, 4'd15, r);
        check("midclr_rd", 32'(r), 32'h0000);

        // Random traffic vs model.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 150; i++) begin
                access(d, 1'($urandom_range(0, 1)), 4'($urandom),
                       16'($urandom), 4'($urandom), r);
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk);
                    #1;
                    check("rd_hold_idle", 32'(rd[d]), 32'(r));
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
